// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 4-bit sequencer: FSM states,
// power-on init tables and the slow (clear/home) command decode.
package lcd_seq_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      IDLE,
      SETUP,
      E_HI,
      E_LO,
      DELAY
   } lcd_state_e;

   typedef struct packed {
      logic       single;
      logic [7:0] data;
   } init_item_t;

   localparam int unsigned INIT_ITEMS = 8;

   // Element [0] is sent first.
   localparam logic [3:0][3:0] INIT_NIBBLES = {4'h2, 4'h3, 4'h3, 4'h3};
   localparam logic [3:0][7:0] INIT_BYTES   = {8'h06, 8'h01, 8'h0C, 8'h28};

   // Commands 0x01..0x03 (clear, return home) need the long settle time.
   localparam logic [7:0] SLOW_CMD_MAX = 8'h03;

   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data != 8'h00) && (data <= SLOW_CMD_MAX);
   endfunction

   // Items 0..3 are single wake-up nibbles, 4..7 are full command bytes.
   function automatic init_item_t init_item(input logic [2:0] idx);
      init_item_t item;
      if (!idx[2]) begin
         item.single = 1'b1;
         item.data   = {4'h0, INIT_NIBBLES[idx[1:0]]};
      end else begin
         item.single = 1'b0;
         item.data   = INIT_BYTES[idx[1:0]];
      end
      return item;
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// One HD44780 nibble strobe: SETUP, E high, E low with data held.
// done_c marks the last E-low cycle; a start in that cycle chains directly.
module lcd_nibble_tx
   import lcd_seq_pkg::*;
#(
   parameter int unsigned E_HIGH_CYC = 20,
   parameter int unsigned E_LOW_CYC  = 20,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] nibble,
   input  logic       nibble_rs,
   output logic       e,
   output logic       rs,
   output logic [3:0] d,
   output logic       done_c
);

   lcd_state_e       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             load_c;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_c  = 1'b0;
      load_c  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load_c  = 1'b1;
               state_n = SETUP;
               cnt_n   = '0;
            end
         end
         SETUP: begin
            state_n = E_HI;
            cnt_n   = CNT_W'(E_HIGH_CYC - 1);
         end
         E_HI: begin
            if (cnt == '0) begin
               state_n = E_LO;
               cnt_n   = CNT_W'(E_LOW_CYC - 1);
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         E_LO: begin
            if (cnt == '0) begin
               done_c = 1'b1;
               cnt_n  = '0;
               if (start) begin
                  load_c  = 1'b1;
                  state_n = SETUP;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // RS/D change only when a new nibble is loaded, so they hold through E_LO and idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         e     <= 1'b0;
         rs    <= 1'b0;
         d     <= 4'h0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         e     <= (state_n == E_HI);
         if (load_c) begin
            rs <= nibble_rs;
            d  <= nibble;
         end
      end
   end

endmodule

// File: rtl/lcd4_sequencer.sv
// HD44780 4-bit bus write sequencer: byte handshake, nibble split, post-byte delays.
// Define LCD_AUTO_INIT_EN to run the power-up init sequence after reset.
module lcd4_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int unsigned PWR_CYC       = 800000,
   parameter int unsigned E_HIGH_CYC    = 20,
   parameter int unsigned E_LOW_CYC     = 20,
   parameter int unsigned CMD_DELAY_CYC = 2000,
   parameter int unsigned CLR_DELAY_CYC = 80000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   output logic       init_done,
   output logic       RS,
   output logic       E,
   output logic       D4,
   output logic       D5,
   output logic       D6,
   output logic       D7
);

   localparam int unsigned MAX_A   = (PWR_CYC > CLR_DELAY_CYC) ? PWR_CYC : CLR_DELAY_CYC;
   localparam int unsigned MAX_B   = (E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC;
   localparam int unsigned MAX_C   = (MAX_B > CMD_DELAY_CYC) ? MAX_B : CMD_DELAY_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   lcd_state_e       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       byte_q, byte_n;
   logic             rs_q, rs_n;
   logic             hi_q, hi_n;
   logic             single_q, single_n;
   logic             init_done_n;
   logic             launch_c;
   logic [7:0]       launch_data;
   logic             launch_rs;
   logic             launch_single;
   logic             start_c;
   logic [3:0]       nib_c;
   logic             nib_rs_c;
   logic             tx_done_c;
   logic [3:0]       tx_d;
`ifdef LCD_AUTO_INIT_EN
   logic [2:0]       init_idx, init_idx_n;
   init_item_t       item_c;
`endif

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      byte_n        = byte_q;
      rs_n          = rs_q;
      hi_n          = hi_q;
      single_n      = single_q;
      launch_c      = 1'b0;
      launch_data   = in_data;
      launch_rs     = in_rs;
      launch_single = 1'b0;
      start_c       = 1'b0;
      nib_c         = byte_q[3:0];
      nib_rs_c      = rs_q;
`ifdef LCD_AUTO_INIT_EN
      init_done_n = init_done;
      init_idx_n  = init_idx;
      item_c      = init_item((state == PWR_WAIT) ? 3'd0 : 3'(init_idx + 3'd1));
`else
      init_done_n = 1'b1;
`endif
      unique case (state)
`ifdef LCD_AUTO_INIT_EN
         PWR_WAIT: begin
            if (cnt == '0) begin
               launch_c      = 1'b1;
               launch_data   = item_c.data;
               launch_rs     = 1'b0;
               launch_single = item_c.single;
               init_idx_n    = 3'd0;
               state_n       = INIT;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         INIT,
`endif
         SETUP: begin
            // High nibble done: chain the low nibble with no gap; else settle.
            if (tx_done_c) begin
               if (hi_q) begin
                  start_c  = 1'b1;
                  nib_c    = byte_q[3:0];
                  nib_rs_c = rs_q;
                  hi_n     = 1'b0;
               end else begin
                  state_n = DELAY;
                  cnt_n   = (!single_q && is_slow_cmd(rs_q, byte_q)) ?
                            CNT_W'(CLR_DELAY_CYC - 1) : CNT_W'(CMD_DELAY_CYC - 1);
               end
            end
         end
         IDLE: begin
            if (in_valid && in_ready) begin
               launch_c = 1'b1;
               state_n  = SETUP;
            end
         end
         DELAY: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
`ifdef LCD_AUTO_INIT_EN
               if (!init_done) begin
                  if (init_idx == 3'(INIT_ITEMS - 1)) begin
                     state_n     = IDLE;
                     init_done_n = 1'b1;
                  end else begin
                     init_idx_n    = 3'(init_idx + 3'd1);
                     launch_c      = 1'b1;
                     launch_data   = item_c.data;
                     launch_rs     = 1'b0;
                     launch_single = item_c.single;
                     state_n       = INIT;
                  end
               end else begin
                  state_n = IDLE;
               end
`else
               state_n = IDLE;
`endif
            end
         end
         default: state_n = IDLE;
      endcase

      if (launch_c) begin
         start_c  = 1'b1;
         nib_c    = launch_single ? launch_data[3:0] : launch_data[7:4];
         nib_rs_c = launch_rs;
         byte_n   = launch_data;
         rs_n     = launch_rs;
         single_n = launch_single;
         hi_n     = !launch_single;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
`ifdef LCD_AUTO_INIT_EN
         state    <= PWR_WAIT;
         cnt      <= CNT_W'(PWR_CYC - 1);
         init_idx <= 3'd0;
`else
         state    <= IDLE;
         cnt      <= '0;
`endif
         byte_q    <= 8'h00;
         rs_q      <= 1'b0;
         hi_q      <= 1'b0;
         single_q  <= 1'b0;
         in_ready  <= 1'b0;
         init_done <= 1'b0;
      end else begin
`ifdef LCD_AUTO_INIT_EN
         init_idx <= init_idx_n;
`endif
         state     <= state_n;
         cnt       <= cnt_n;
         byte_q    <= byte_n;
         rs_q      <= rs_n;
         hi_q      <= hi_n;
         single_q  <= single_n;
         in_ready  <= (state_n == IDLE);
         init_done <= init_done_n;
      end
   end

   lcd_nibble_tx #(
      .E_HIGH_CYC (E_HIGH_CYC),
      .E_LOW_CYC  (E_LOW_CYC),
      .CNT_W      (CNT_W)
   ) u_nibble_tx (
      .clk       (CLK),
      .rst       (RST),
      .start     (start_c),
      .nibble    (nib_c),
      .nibble_rs (nib_rs_c),
      .e         (E),
      .rs        (RS),
      .d         (tx_d),
      .done_c    (tx_done_c)
   );

   assign D4 = tx_d[0];
   assign D5 = tx_d[1];
   assign D6 = tx_d[2];
   assign D7 = tx_d[3];

endmodule

// File: tb/tb_lcd4_sequencer.sv
// Scoreboard bench for lcd4_sequencer: expected nibbles and in_ready return
// times are queued at stimulus, and a negedge monitor pops and compares them.
module tb_lcd4_sequencer;

   localparam int unsigned PWR = 20;
   localparam int unsigned EH  = 2;
   localparam int unsigned EL  = 2;
   localparam int unsigned CMD = 4;
   localparam int unsigned CLR = 10;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_rs = 1'b0;
   logic       in_ready, init_done, RS, E, D4, D5, D6, D7;

   lcd4_sequencer #(
      .PWR_CYC       (PWR),
      .E_HIGH_CYC    (EH),
      .E_LOW_CYC     (EL),
      .CMD_DELAY_CYC (CMD),
      .CLR_DELAY_CYC (CLR)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_rs     (in_rs),
      .init_done (init_done),
      .RS        (RS),
      .E         (E),
      .D4        (D4),
      .D5        (D5),
      .D6        (D6),
      .D7        (D7)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   typedef struct packed {
      logic       rs;
      logic [3:0] nib;
   } nib_t;

   nib_t exp_nib[$];
   int   exp_rdy[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   first_e_cyc = -1;

   task automatic chk(input bit ok, input string name, input longint act, input longint expv);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
   endtask

   // Reference: in_ready returns 1 + two nibble slots + settle time after acceptance.
   function automatic int byte_latency(input logic [7:0] d, input logic rs);
      int settle;
      settle = (!rs && d >= 8'd1 && d <= 8'd3) ? CLR : CMD;
      return 1 + 2 * (1 + EH + EL) + settle;
   endfunction

   task automatic push_byte(input logic [7:0] d, input logic rs, input int acc);
      nib_t n;
      n.rs = rs; n.nib = d[7:4]; exp_nib.push_back(n);
      n.rs = rs; n.nib = d[3:0]; exp_nib.push_back(n);
      exp_rdy.push_back(acc + byte_latency(d, rs));
   endtask

   task automatic push_init(input int rel);
      logic [3:0] nibs [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
      logic [7:0] cmds [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};
      nib_t n;
      int t;
      t = rel + PWR;
      foreach (nibs[i]) begin
         n.rs = 1'b0; n.nib = nibs[i]; exp_nib.push_back(n);
         t += 1 + EH + EL + CMD;
      end
      foreach (cmds[i]) begin
         n.rs = 1'b0; n.nib = cmds[i][7:4]; exp_nib.push_back(n);
         n.rs = 1'b0; n.nib = cmds[i][3:0]; exp_nib.push_back(n);
         t += byte_latency(cmds[i], 1'b0) - 1;
      end
      exp_rdy.push_back(t);
   endtask

   // Monitor: compare every E pulse and every in_ready rise against the queues.
   logic e_prev = 1'b0, rdy_prev = 1'b0;
   int   e_len = 0;
   nib_t at_rise;
   always @(negedge CLK) begin
      if (RST) begin
         e_len = 0;
      end else begin
         if (E && !e_prev) begin
            if (first_e_cyc < 0) first_e_cyc = cyc;
            at_rise = {RS, D7, D6, D5, D4};
            if (exp_nib.size() == 0) begin
               chk(1'b0, "unexpected_e_pulse", at_rise, -1);
            end else begin
               nib_t x;
               x = exp_nib.pop_front();
               chk(at_rise == x, "nibble_rs", at_rise, x);
            end
         end
         if (E) e_len++;
         if (!E && e_prev) begin
            chk(e_len == EH, "e_high_len", e_len, EH);
            chk({RS, D7, D6, D5, D4} == at_rise, "bus_hold_after_e", {RS, D7, D6, D5, D4}, at_rise);
            e_len = 0;
         end
         if (in_ready && !rdy_prev) begin
            if (exp_rdy.size() == 0) begin
               chk(1'b0, "unexpected_ready", cyc, -1);
            end else begin
               int t;
               t = exp_rdy.pop_front();
               chk(cyc == t, "ready_cycle", cyc, t);
            end
         end
      end
      e_prev   = E;
      rdy_prev = in_ready;
   end

   task automatic send_byte(input logic [7:0] d, input logic rs, input bit hold);
      bit ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         if (in_ready) begin
            in_valid = 1'b1; in_data = d; in_rs = rs;
            push_byte(d, rs, cyc);
            ok = 1'b1;
            break;
         end
         if (hold) begin
            in_valid = 1'b1; in_data = d; in_rs = rs;
         end else begin
            in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom); in_rs = 1'($urandom);
         end
      end
      if (!ok) chk(1'b0, "accept_timeout", 0, 1);
      @(posedge CLK);
      #1;
      if (!hold) begin
         in_valid = 1'b0; in_data = 8'($urandom); in_rs = 1'($urandom);
      end
   endtask

   task automatic drain(input int limit);
      for (int n = 0; n < limit && (exp_nib.size() != 0 || exp_rdy.size() != 0); n++)
         @(negedge CLK);
      chk(exp_nib.size() == 0, "nibbles_outstanding", exp_nib.size(), 0);
      chk(exp_rdy.size() == 0, "ready_outstanding", exp_rdy.size(), 0);
   endtask

   task automatic release_reset();
      int rel;
      @(negedge CLK);
      RST = 1'b0;
      rel = cyc;
`ifdef LCD_AUTO_INIT_EN
      first_e_cyc = -1;
      push_init(rel);
      drain(1000);
      chk(first_e_cyc - rel == 21, "first_e_rise_cycle", first_e_cyc - rel, 21);
      chk(init_done == 1'b1, "init_done_after_init", init_done, 1);
      chk(in_ready == 1'b1, "ready_after_init", in_ready, 1);
`else
      exp_rdy.push_back(rel + 1);
      @(negedge CLK);
      chk(in_ready == 1'b1, "ready_after_rst", in_ready, 1);
      chk(init_done == 1'b1, "init_done_after_rst", init_done, 1);
      chk(E == 1'b0, "e_idle_after_rst", E, 0);
`endif
   endtask

   initial begin
      logic [7:0] d;
      bit got_e;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk(E == 1'b0, "rst_e", E, 0);
      chk(RS == 1'b0, "rst_rs", RS, 0);
      chk({D7, D6, D5, D4} == 4'h0, "rst_d", {D7, D6, D5, D4}, 0);
      chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
      chk(init_done == 1'b0, "rst_init_done", init_done, 0);
      release_reset();

      // Directed: data write, clear/home boundaries, back-to-back with valid held.
      send_byte(8'h41, 1'b1, 1'b0); drain(200);
      send_byte(8'h01, 1'b0, 1'b0); drain(200);
      send_byte(8'h01, 1'b1, 1'b0); drain(200);
      send_byte(8'h00, 1'b0, 1'b0); drain(200);
      send_byte(8'h03, 1'b0, 1'b0); drain(200);
      send_byte(8'h04, 1'b0, 1'b0); drain(200);
      send_byte(8'h48, 1'b1, 1'b1);
      send_byte(8'h49, 1'b1, 1'b0);
      drain(200);

      for (int i = 0; i < 24; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         send_byte(d, 1'($urandom), (i != 23) ? 1'($urandom) : 1'b0);
      end
      drain(2000);

      // Reset while E is high abandons the byte.
      send_byte(8'h5A, 1'b1, 1'b0);
      got_e = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge CLK);
         if (E) begin got_e = 1'b1; break; end
      end
      chk(got_e, "e_seen_before_reset", got_e, 1);
      RST = 1'b1;
      @(negedge CLK);
      chk(E == 1'b0, "midrst_e", E, 0);
      chk(in_ready == 1'b0, "midrst_in_ready", in_ready, 0);
      chk(init_done == 1'b0, "midrst_init_done", init_done, 0);
      exp_nib.delete();
      exp_rdy.delete();
      release_reset();
      send_byte(8'h02, 1'b0, 1'b0);
      drain(200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
